fc_spike_index_issuer: RTL
==========================

# fc_spike_index_issuer

Transmit end of the FC spike-index interface. The block buffers one frame of active presynaptic spike indices from the upstream layer. It then replays the whole list once per output channel as an `s_index_valid`/`s_index_ram` beat stream, with `addr_most` held constant, into an FC processing element. It waits for the PE's `ram_release` before reporting the frame complete and accepting the next frame.

## Interface
- `DEPTH`, 128: maximum spikes per frame (buffer entries); pointer width `$clog2(DEPTH)`.
- `OUTPUT_CHANNEL_NUM`, 256: passes over the list per frame.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_valid` in 1: upstream spike-index write strobe.
- `wr_index` in `SYNAPSE_INDEX`: spike index to store.
- `frame_end` in 1: end of input frame; may coincide with `wr_valid`.
- `wr_ready` out 1: high only in IDLE; writes and `frame_end` are ignored otherwise.
- `pe_stall` in 1: downstream hold request (see Configuration).
- `ram_release` in 1: PE pulse, frame consumed.
- `s_index_ram` out `SYNAPSE_INDEX`: index beat.
- `s_index_valid` out 1: beat qualifier.
- `addr_most` out `CONV1_ADDR`: spike count minus 1, stable for the whole frame.
- `channel_cnt` out `CHANNEL_WIDE`: current output-channel pass.
- `busy` out 1: state is not IDLE.
- `frame_done` out 1: one-cycle completion pulse.
- `overflow` out 1: sticky, more than `DEPTH` writes in the current frame.

## Operation
- States: IDLE, ISSUE, WAIT_REL, DONE.
- **IDLE**
  - `wr_valid` stores `wr_index` at `buf[wr_ptr]`, then increments `wr_ptr`.
  - When `wr_ptr==DEPTH`, the write is dropped and `overflow` is set.
  - A write on the same cycle as `frame_end` is included in the frame.
  - On `frame_end`, `cnt` is the final `wr_ptr` (including any same-cycle write):
    - `cnt==0`: go to DONE; no beats are issued.
    - Otherwise: `addr_most<=cnt-1`, `rd_ptr<=0`, `channel_cnt<=0`, go to ISSUE.
- **ISSUE**, on each non-stalled cycle:
  - Issue one beat from `buf[rd_ptr]`.
  - `rd_ptr` wraps from `cnt-1` to 0; `channel_cnt` increments on each wrap.
  - After the beat at `rd_ptr==cnt-1` and `channel_cnt==OUTPUT_CHANNEL_NUM-1`:
    - if `cnt==1`, go to DONE (`ram_release` is not awaited for single-spike frames);
    - otherwise, go to WAIT_REL.
  - Total beats per frame: `cnt*OUTPUT_CHANNEL_NUM`, in order `buf[0..cnt-1]` repeated.
- **Release capture**: `rel_seen` is set by `ram_release` at any time in ISSUE or WAIT_REL, so an early release pulse is not lost.
- **WAIT_REL**: when `rel_seen` (or `ram_release` this cycle) is set, go to DONE.
- **DONE** (one cycle):
  - `frame_done=1`.
  - Clear `wr_ptr` and `rel_seen`; go to IDLE.
  - `overflow` clears at the first write of the next frame.
- `ram_release` is ignored in IDLE and DONE.

## Timing
- All outputs are registered.
- Reset values: `s_index_ram=0`, `s_index_valid=0`, `addr_most=0`, `channel_cnt=0`, `busy=0`, `frame_done=0`, `overflow=0`, `wr_ready=1`.
- Reset mid-frame: return to IDLE and drop buffer contents and pointers at once; no further beats.
- Buffer read is synchronous; the beat chosen in cycle N appears on the outputs in cycle N+1.
- `frame_end` sampled at edge T:
  - `busy` rises at T+1.
  - First `s_index_valid` is high after edge T+2.
  - Beats are then back-to-back (100 % duty) unless stalled.
- `addr_most` changes only on the IDLE→ISSUE transition.
- `channel_cnt` changes coincident with the first beat of the new pass.
- `frame_done` is high exactly one cycle after the last beat (`cnt==1` case), or one cycle after release is seen, whichever is later.
- `cnt==0` frame: `frame_done` is high 2 cycles after `frame_end`.

## Configuration
- Macro `FC_ISSUE_STALL_EN`.
- Defined: `pe_stall` high in ISSUE
  - suppresses the beat (`s_index_valid=0` next cycle);
  - holds `rd_ptr`/`channel_cnt`;
  - the sequence resumes unbroken when `pe_stall` falls.
- Undefined: `pe_stall` is ignored and the block always issues one beat per ISSUE cycle.

## Test plan
- Reset, then assert `rst` mid-ISSUE → all outputs return to reset values on the next edge, `wr_ready=1`, no beats until a new frame.
- `OUTPUT_CHANNEL_NUM=4`; write 5, 9, 17 with `frame_end` on the third write → `addr_most=2`, exactly 12 beats `5,9,17`×4, `channel_cnt` 0→3. Then a `ram_release` pulse → one-cycle `frame_done`.
- `frame_end` with no writes → no `s_index_valid`, `frame_done` 2 cycles later.
- Single spike 42 (`OUTPUT_CHANNEL_NUM=4`) → 4 beats of 42, `addr_most=0`, `frame_done` with no `ram_release`.
- `DEPTH=4`; write 6 indices (1..6) → `overflow=1`, beats `1,2,3,4` per pass, `addr_most=3`. `ram_release` pulsed during ISSUE → `frame_done` right after the last beat.
- `FC_ISSUE_STALL_EN` defined: `pe_stall` high 3 cycles mid-pass → 3 cycles of `s_index_valid=0`, no skipped or repeated index. Undefined: same stimulus → no gap in beats.

Source files
------------

// File: rtl/fc_spike_index_issuer_if.sv
// Spike-index beat stream between the FC issuer and an FC processing element.
// The master drives beats and frame metadata; the slave returns stall and release.
interface fc_spike_index_issuer_if #(
  parameter int SYNAPSE_INDEX = 16,
  parameter int CONV1_ADDR    = 7,
  parameter int CHANNEL_WIDE  = 8
);
  logic [SYNAPSE_INDEX-1:0] s_index_ram;
  logic                     s_index_valid;
  logic [CONV1_ADDR-1:0]    addr_most;
  logic [CHANNEL_WIDE-1:0]  channel_cnt;
  logic                     pe_stall;
  logic                     ram_release;

  modport master (
    output s_index_ram,
    output s_index_valid,
    output addr_most,
    output channel_cnt,
    input  pe_stall,
    input  ram_release
  );

  modport slave (
    input  s_index_ram,
    input  s_index_valid,
    input  addr_most,
    input  channel_cnt,
    output pe_stall,
    output ram_release
  );
endinterface

// File: rtl/fc_spike_index_issuer.sv
// Buffers one frame of spike indices and replays it once per output channel to an FC PE.
// Define FC_ISSUE_STALL_EN to let pe_stall hold the beat stream during ISSUE.
module fc_spike_index_issuer #(
  parameter int DEPTH              = 128,
  parameter int OUTPUT_CHANNEL_NUM = 256,
  parameter int SYNAPSE_INDEX      = 16,
  parameter int CONV1_ADDR         = $clog2(DEPTH),
  parameter int CHANNEL_WIDE       = $clog2(OUTPUT_CHANNEL_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [SYNAPSE_INDEX-1:0] wr_index,
  input  logic                     frame_end,
  output logic                     wr_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overflow,
  fc_spike_index_issuer_if.master  pe
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]        DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CHANNEL_WIDE-1:0] CH_LAST = CHANNEL_WIDE'(OUTPUT_CHANNEL_NUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_REL,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [SYNAPSE_INDEX-1:0] mem [DEPTH];
  logic [CNT_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         last_ptr;
  logic [CHANNEL_WIDE-1:0]  ch_cnt;
  logic                     single;
  logic                     rel_seen;

  logic [SYNAPSE_INDEX-1:0] rd_data;
  logic                     rd_valid;
  logic [CHANNEL_WIDE-1:0]  rd_ch;
  logic                     done_p;

  logic             wr_accept;
  logic [CNT_W-1:0] cnt_final;
  logic             start;
  logic             issue_go;
  logic             last_beat;
  logic             rel_hit;

  always_comb begin
    wr_accept = (state == IDLE) && wr_valid && (wr_ptr != DEPTH_C);
    cnt_final = wr_ptr + CNT_W'(wr_accept);
    start     = (state == IDLE) && frame_end && (cnt_final != '0);
`ifdef FC_ISSUE_STALL_EN
    issue_go  = (state == ISSUE) && !pe.pe_stall;
`else
    issue_go  = (state == ISSUE);
`endif
    last_beat = issue_go && (rd_ptr == last_ptr) && (ch_cnt == CH_LAST);
    rel_hit   = rel_seen || pe.ram_release;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (frame_end) state_nx = (cnt_final == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        // A release already captured lets the frame close right after its last beat.
        if (last_beat) state_nx = (single || rel_hit) ? DONE : WAIT_REL;
      end
      WAIT_REL: begin
        if (rel_hit) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Spike buffer behaves as a plain RAM: no reset, synchronous read.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr[PTR_W-1:0]] <= wr_index;
    if (issue_go)  rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      last_ptr         <= '0;
      ch_cnt           <= '0;
      single           <= 1'b0;
      rel_seen         <= 1'b0;
      rd_valid         <= 1'b0;
      rd_ch            <= '0;
      done_p           <= 1'b0;
      wr_ready         <= 1'b1;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      overflow         <= 1'b0;
      pe.s_index_ram   <= '0;
      pe.s_index_valid <= 1'b0;
      pe.addr_most     <= '0;
      pe.channel_cnt   <= '0;
    end else begin
      wr_ready   <= (state_nx == IDLE);
      busy       <= (state != IDLE);
      done_p     <= (state == DONE);
      frame_done <= done_p;

      if (wr_accept)          wr_ptr <= wr_ptr + CNT_W'(1);
      else if (state == DONE) wr_ptr <= '0;

      if ((state == IDLE) && wr_valid) begin
        if (wr_ptr == '0)     overflow <= 1'b0;
        if (wr_ptr == DEPTH_C) overflow <= 1'b1;
      end

      if (state == DONE)
        rel_seen <= 1'b0;
      else if (((state == ISSUE) || (state == WAIT_REL)) && pe.ram_release)
        rel_seen <= 1'b1;

      rd_valid <= issue_go;
      if (issue_go) begin
        rd_ch <= ch_cnt;
        if (rd_ptr == last_ptr) begin
          rd_ptr <= '0;
          ch_cnt <= ch_cnt + CHANNEL_WIDE'(1);
        end else begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end

      // Output stage trails the RAM read by one cycle; channel_cnt rides with its beat.
      pe.s_index_valid <= rd_valid;
      if (rd_valid) begin
        pe.s_index_ram <= rd_data;
        pe.channel_cnt <= rd_ch;
      end

      if (start) begin
        last_ptr       <= PTR_W'(cnt_final - CNT_W'(1));
        single         <= (cnt_final == CNT_W'(1));
        pe.addr_most   <= CONV1_ADDR'(cnt_final - CNT_W'(1));
        rd_ptr         <= '0;
        ch_cnt         <= '0;
        rd_ch          <= '0;
        pe.channel_cnt <= '0;
      end
    end
  end

endmodule
